// File: rtl/instr_exec_blck_pkg.sv
// Shared opcode encoding, instruction field positions and default widths for the execute stage.
package instr_exec_blck_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned REG_N_DEF  = 8;
  localparam int unsigned INSTR_W    = 8;
  localparam int unsigned ADDR_W     = 3;
  localparam int unsigned JMP_W      = 6;

  localparam int unsigned OP_MSB = 7;
  localparam int unsigned OP_LSB = 6;
  localparam int unsigned RD_MSB = 5;
  localparam int unsigned RD_LSB = 3;
  localparam int unsigned RS_MSB = 2;
  localparam int unsigned RS_LSB = 0;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_MOVI = 2'b01,
    OP_SUB  = 2'b10,
    OP_JMP  = 2'b11
  } opcode_e;

endpackage

// File: rtl/reg_file_blck.sv
// Register file: two combinational read ports, one synchronous write port, synchronous clear.
module reg_file_blck
  import instr_exec_blck_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_N  = REG_N_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [REG_N];

  // Clear wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(REG_N); i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = mem[rd_addr_a];
  assign rd_data_b = mem[rd_addr_b];

endmodule

// File: rtl/instr_exec_blck.sv
// Execute stage: captures the fetched instruction, decodes and executes it, squashes behind taken jumps.
// Define ZERO_JMP_EN to turn opcode 11 into JZ (jump only when Z is set).
module instr_exec_blck
  import instr_exec_blck_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned REG_N  = REG_N_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        instr_code,
  output logic              branch,
  output logic [5:0]        jmpaddr,
  output logic              wb_en,
  output logic [2:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              zero_flag,
  output logic              ir_valid
);

  logic [INSTR_W-1:0] ir;
  logic               z_q;

  opcode_e            op;
  logic [ADDR_W-1:0]  rd;
  logic [ADDR_W-1:0]  rs;
  logic [DATA_W-1:0]  rd_val;
  logic [DATA_W-1:0]  rs_val;
  logic [DATA_W-1:0]  result;
  logic               is_jmp;
  logic               jmp_cond;
  logic               z_upd;

  reg_file_blck #(
    .DATA_W (DATA_W),
    .REG_N  (REG_N)
  ) u_reg_file (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (rd),
    .rd_data_a (rd_val),
    .rd_addr_b (rs),
    .rd_data_b (rs_val),
    .wr_en     (wb_en),
    .wr_addr   (rd),
    .wr_data   (result)
  );

  // Decode, ALU and control, all combinational from IR.
  always_comb begin
    op       = opcode_e'(ir[OP_MSB:OP_LSB]);
    rd       = ir[RD_MSB:RD_LSB];
    rs       = ir[RS_MSB:RS_LSB];
    result   = '0;
    is_jmp   = 1'b0;
    z_upd    = 1'b0;
`ifdef ZERO_JMP_EN
    jmp_cond = z_q;
`else
    jmp_cond = 1'b1;
`endif

    case (op)
      OP_ADD: begin
        result = rd_val + rs_val;
        z_upd  = ir_valid;
      end
      OP_MOVI: result = DATA_W'(rs);
      OP_SUB: begin
        result = rd_val - rs_val;
        z_upd  = ir_valid;
      end
      default: is_jmp = 1'b1;
    endcase

    branch  = ir_valid & is_jmp & jmp_cond;
    jmpaddr = is_jmp ? ir[JMP_W-1:0] : '0;
    wb_en   = ir_valid & ~is_jmp;
    wb_addr = wb_en ? rd : '0;
    wb_data = wb_en ? result : '0;
  end

  // Capture stage and Z flag; a taken branch marks the next captured slot invalid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ir       <= '0;
      ir_valid <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      ir       <= instr_code;
      ir_valid <= ~branch;
      if (z_upd) begin
        z_q <= (result == '0);
      end
    end
  end

  assign zero_flag = z_q;

endmodule
